// File: rtl/uart_work_pkg.sv
// Shared encodings and defaults for the UART work path (assembler and TX nonce reporter).
package uart_work_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSEMBLE = 2'd1,
    ST_CHECK    = 2'd2,
    ST_COMMIT   = 2'd3
  } work_state_e;

  localparam int unsigned DEFAULT_PAYLOAD_BYTES  = 44;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte watchdog: counts while enabled, restarts on clear, flags the last allowed cycle.
module uart_frame_timer
  import uart_work_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt;

  assign expire_c = enable & ~clear & (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || expire_c) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/uart_work_assembler.sv
// Assembles UART bytes into a double-buffered work frame for the hashing core.
// Define WORK_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module uart_work_assembler
  import uart_work_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES  = DEFAULT_PAYLOAD_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       received,
  input  logic [7:0]                 rx_byte,
  input  logic                       recv_error,
  output logic [PAYLOAD_BYTES*8-1:0] work_data,
  output logic                       work_valid,
  input  logic                       work_ready,
  output logic                       frame_error,
  output logic                       frame_timeout,
  output logic                       overrun
);

  localparam int unsigned DATA_W = PAYLOAD_BYTES * 8;
  localparam int unsigned CNT_W  = $clog2(PAYLOAD_BYTES + 2);
`ifdef WORK_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = PAYLOAD_BYTES + 1;
`else
  localparam int unsigned FRAME_BYTES = PAYLOAD_BYTES;
`endif
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BYTES);

  work_state_e       state, state_n;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_n, base_cnt_c;
  logic [DATA_W-1:0] shift_reg, shift_reg_n, work_data_n;
  logic              err_pend, err_pend_n;
  logic              work_valid_n, frame_error_n, frame_timeout_n, overrun_n;
  logic              take_c, timer_clear_c, timer_en_c, expire_c;
`ifdef WORK_CHECKSUM_EN
  localparam logic [CNT_W-1:0] PAYLOAD_CNT = CNT_W'(PAYLOAD_BYTES);
  logic [7:0]        acc, acc_n, base_acc_c;
`endif

  uart_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear_c),
    .enable  (timer_en_c),
    .expire_c(expire_c)
  );

  // Next-state and next-output logic; a byte taken in COMMIT starts the next frame.
  always_comb begin
    state_n         = state;
    byte_cnt_n      = byte_cnt;
    shift_reg_n     = shift_reg;
    err_pend_n      = 1'b0;
    work_data_n     = work_data;
    work_valid_n    = work_valid & ~work_ready;
    frame_error_n   = 1'b0;
    frame_timeout_n = 1'b0;
    overrun_n       = 1'b0;
    take_c          = 1'b0;
    base_cnt_c      = byte_cnt;
    timer_en_c      = (state == ST_ASSEMBLE);
    timer_clear_c   = (state != ST_ASSEMBLE) | received | recv_error | err_pend;
`ifdef WORK_CHECKSUM_EN
    acc_n      = acc;
    base_acc_c = acc;
`endif

    case (state)
      ST_COMMIT: begin
        if (!work_valid || work_ready) begin
          work_data_n  = shift_reg;
          work_valid_n = 1'b1;
        end else begin
          overrun_n = 1'b1;
        end
        state_n    = ST_IDLE;
        byte_cnt_n = '0;
        err_pend_n = recv_error | err_pend;
        base_cnt_c = '0;
        take_c     = received & ~recv_error;
`ifdef WORK_CHECKSUM_EN
        acc_n      = '0;
        base_acc_c = '0;
`endif
      end
`ifdef WORK_CHECKSUM_EN
      ST_CHECK: begin
        state_n    = ST_IDLE;
        byte_cnt_n = '0;
        acc_n      = '0;
        if (!recv_error && acc == 8'h00) begin
          state_n = ST_COMMIT;
        end else begin
          frame_error_n = 1'b1;
        end
      end
`endif
      default: begin
        if (recv_error || err_pend) begin
          frame_error_n = 1'b1;
          state_n       = ST_IDLE;
          byte_cnt_n    = '0;
`ifdef WORK_CHECKSUM_EN
          acc_n         = '0;
`endif
        end else if (received) begin
          take_c = 1'b1;
        end else if (expire_c) begin
          frame_timeout_n = 1'b1;
          state_n         = ST_IDLE;
          byte_cnt_n      = '0;
`ifdef WORK_CHECKSUM_EN
          acc_n           = '0;
`endif
        end
      end
    endcase

    if (take_c) begin
      byte_cnt_n = base_cnt_c + CNT_W'(1);
`ifdef WORK_CHECKSUM_EN
      acc_n = base_acc_c ^ rx_byte;
      if (base_cnt_c < PAYLOAD_CNT) begin
        shift_reg_n = DATA_W'({shift_reg, rx_byte});
      end
      state_n = (byte_cnt_n >= FRAME_CNT) ? ST_CHECK : ST_ASSEMBLE;
`else
      shift_reg_n = DATA_W'({shift_reg, rx_byte});
      state_n = (byte_cnt_n >= FRAME_CNT) ? ST_COMMIT : ST_ASSEMBLE;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      byte_cnt      <= '0;
      shift_reg     <= '0;
      err_pend      <= 1'b0;
      work_data     <= '0;
      work_valid    <= 1'b0;
      frame_error   <= 1'b0;
      frame_timeout <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_n;
      byte_cnt      <= byte_cnt_n;
      shift_reg     <= shift_reg_n;
      err_pend      <= err_pend_n;
      work_data     <= work_data_n;
      work_valid    <= work_valid_n;
      frame_error   <= frame_error_n;
      frame_timeout <= frame_timeout_n;
      overrun       <= overrun_n;
    end
  end

`ifdef WORK_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc_n;
    end
  end
`endif

endmodule

// File: tb/tb_uart_work_assembler.sv
// Randomized scoreboard bench for uart_work_assembler (honours WORK_CHECKSUM_EN).
module tb_uart_work_assembler;

  localparam int unsigned N  = 44;
  localparam int unsigned TO = 300;
  localparam int unsigned DW = N * 8;
`ifdef WORK_CHECKSUM_EN
  localparam int FB = N + 1;
  localparam int LAT = 3;
  localparam int FIRST_MIN = 1;
`else
  localparam int FB = N;
  localparam int LAT = 2;
  localparam int FIRST_MIN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          received = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          recv_error = 1'b0;
  logic          work_ready = 1'b0;
  logic [DW-1:0] work_data;
  logic          work_valid, frame_error, frame_timeout, overrun;

  int total = 0;
  int bad = 0;
  int obs_err = 0, obs_to = 0, obs_ovr = 0;
  int exp_err = 0, exp_to = 0, exp_ovr = 0;
  bit held = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [7:0] fbuf[64];

  uart_work_assembler #(
    .PAYLOAD_BYTES (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .received     (received),
    .rx_byte      (rx_byte),
    .recv_error   (recv_error),
    .work_data    (work_data),
    .work_valid   (work_valid),
    .work_ready   (work_ready),
    .frame_error  (frame_error),
    .frame_timeout(frame_timeout),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts status pulses and checks every accepted frame against the scoreboard.
  always @(negedge clk) begin
    if (rst == 1'b0) begin
      if (frame_error)   obs_err++;
      if (frame_timeout) obs_to++;
      if (overrun)       obs_ovr++;
      if (work_valid && work_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %0h expected none", work_data);
        end else begin
          chk("frame_data", work_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  function automatic logic [DW-1:0] pack_frame();
    logic [DW-1:0] p = '0;
    for (int i = 0; i < int'(N); i++) p = (p << 8) | DW'(fbuf[i]);
    return p;
  endfunction

  task automatic add_cksum();
`ifdef WORK_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 0; i < int'(N); i++) x ^= fbuf[i];
    fbuf[N] = x;
`endif
  endtask

  task automatic build_rand();
    for (int i = 0; i < int'(N); i++) fbuf[i] = 8'($urandom);
    add_cksum();
  endtask

  task automatic put_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    received = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    received = 1'b0;
  endtask

  // Reference model for a completed frame: one output slot, replaced only when free or consumed.
  task automatic model_commit();
    if (work_ready || !held) begin
      exp_q.push_back(pack_frame());
      if (!work_ready) held = 1'b1;
    end else begin
      exp_ovr++;
    end
  endtask

  task automatic send_frame(input int maxgap);
    for (int i = 0; i < FB; i++)
      put_byte(fbuf[i], (i == 0) ? int'($urandom_range(maxgap + 1, FIRST_MIN)) : int'($urandom_range(maxgap, 0)));
    model_commit();
  endtask

  task automatic settle(input string tag);
    int k = 0;
    while (work_ready && exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    chk({tag, "_error_pulses"}, DW'(obs_err), DW'(exp_err));
    chk({tag, "_timeout_pulses"}, DW'(obs_to), DW'(exp_to));
    chk({tag, "_overrun_pulses"}, DW'(obs_ovr), DW'(exp_ovr));
    if (work_ready) chk({tag, "_pending"}, DW'(exp_q.size()), DW'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", DW'(work_valid), DW'(0));
    chk("rst_data", work_data, '0);
    chk("rst_error", DW'(frame_error), DW'(0));
    chk("rst_timeout", DW'(frame_timeout), DW'(0));
    chk("rst_overrun", DW'(overrun), DW'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed frame 0x00..0x2B with latency and single-cycle valid checks
    work_ready = 1'b1;
    for (int i = 0; i < int'(N); i++) fbuf[i] = 8'(i);
    add_cksum();
    for (int i = 0; i < FB; i++) put_byte(fbuf[i], 0);
    model_commit();
    repeat (LAT - 2) @(negedge clk);
    chk("latency_early", DW'(work_valid), DW'(0));
    @(negedge clk);
    chk("latency_on", DW'(work_valid), DW'(1));
    chk("first_byte_msb", DW'(work_data[DW-1 -: 8]), DW'(8'h00));
    chk("last_byte_lsb", DW'(work_data[7:0]), DW'(8'h2B));
    @(negedge clk);
    chk("valid_drop", DW'(work_valid), DW'(0));
    settle("directed");

    // Random frames, ready held high
    for (int f = 0; f < 4; f++) begin
      build_rand();
      send_frame(f % 3);
    end
    settle("random");

    // Back-to-back frames with the core stalled
    work_ready = 1'b0;
    build_rand();
    send_frame(1);
    build_rand();
    send_frame(1);
    repeat (5) @(negedge clk);
    chk("stall_valid_held", DW'(work_valid), DW'(1));
    settle("stall");
    work_ready = 1'b1;
    held = 1'b0;
    settle("stall_release");

    // Partial frame then silence: timeout
    for (int i = 0; i < 10; i++) put_byte(8'($urandom), int'($urandom_range(2, 1)));
    repeat (TO + 20) @(negedge clk);
    exp_to++;
    build_rand();
    send_frame(2);
    settle("timeout");

    // Receiver error after byte 20, then error coincident with a byte
    for (int i = 0; i < 20; i++) put_byte(8'($urandom), int'($urandom_range(2, 1)));
    @(negedge clk);
    recv_error = 1'b1;
    @(negedge clk);
    recv_error = 1'b0;
    exp_err++;
    for (int i = 0; i < 5; i++) put_byte(8'($urandom), 1);
    @(negedge clk);
    received = 1'b1;
    recv_error = 1'b1;
    rx_byte = 8'hA5;
    @(negedge clk);
    received = 1'b0;
    recv_error = 1'b0;
    exp_err++;
    build_rand();
    send_frame(2);
    settle("recv_error");

    // Reset mid-frame with a pending frame
    work_ready = 1'b0;
    build_rand();
    send_frame(1);
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", DW'(work_valid), DW'(1));
    for (int i = 0; i < 30; i++) put_byte(8'($urandom), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_valid", DW'(work_valid), DW'(0));
    chk("mid_reset_data", work_data, '0);
    chk("mid_reset_pulses", DW'({frame_error, frame_timeout, overrun}), DW'(0));
    exp_q.delete();
    held = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    work_ready = 1'b1;
    build_rand();
    send_frame(2);
    settle("after_reset");

`ifdef WORK_CHECKSUM_EN
    // Checksum accept and reject
    for (int i = 0; i < int'(N); i++) fbuf[i] = 8'h01;
    fbuf[N] = 8'h00;
    send_frame(1);
    settle("cksum_good");
    for (int i = 0; i < FB; i++) put_byte((i < int'(N)) ? 8'h01 : 8'hFF, 1);
    exp_err++;
    settle("cksum_bad");
`endif

    chk("scoreboard_empty", DW'(exp_q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
